// File: rtl/alu_share_arbiter.sv
// Two-port round-robin arbiter in front of a single ALU with a registered
// response (id, result, zero flag) and a valid/ready handshake on every port.
module alu_share_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_ctrl,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_ctrl,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state_p1;
  state_t           state_nxt;
  logic             last_grant;
  logic             grant;
  logic             can_accept;
  logic             accept;
  logic [WIDTH-1:0] a_p0;
  logic [WIDTH-1:0] b_p0;
  logic [2:0]       ctrl_p0;
  logic [WIDTH-1:0] alu_p0;
  logic             vld_p0;
  logic             id_p1;
  logic [WIDTH-1:0] result_p1;
  logic             zero_p1;

  // ALUControl decode; unknown codes produce zero so the zero flag reads 1.
  function automatic logic [WIDTH-1:0] alu_eval(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [2:0]       ctrl
  );
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    logic [WIDTH-1:0]        res;
    sa  = $signed(a);
    sb  = $signed(b);
    res = '0;
    case (ctrl)
      3'b000:  res = a + b;
      3'b001:  res = a - b;
      3'b010:  res = a & b;
      3'b011:  res = a | b;
      3'b101:  res = {{(WIDTH-1){1'b0}}, (sa < sb)};
      default: res = '0;
    endcase
    return res;
  endfunction

  // Stage 0: arbitration and ALU evaluation on the granted operands.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  assign can_accept = (state_p1 == EMPTY) || rsp_ready;
  assign vld_p0     = grant ? req1_valid : req0_valid;
  assign accept     = can_accept && vld_p0;
  assign req0_ready = can_accept && !grant;
  assign req1_ready = can_accept && grant;

  always_comb begin
    a_p0    = req0_a;
    b_p0    = req0_b;
    ctrl_p0 = req0_ctrl;
    if (grant) begin
      a_p0    = req1_a;
      b_p0    = req1_b;
      ctrl_p0 = req1_ctrl;
    end
  end

  assign alu_p0 = alu_eval(a_p0, b_p0, ctrl_p0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= grant;
    end
  end

  // Stage 1: response register and its occupancy state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_p1 <= EMPTY;
    end else begin
      state_p1 <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state_p1;
    case (state_p1)
      EMPTY: begin
        if (accept) state_nxt = FULL;
      end
      FULL: begin
        if (rsp_ready && !accept) state_nxt = EMPTY;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_comb begin
    rsp_valid = (state_p1 == FULL);
  end

  // The response register is cleared on reset so a discarded result never leaks out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      id_p1     <= 1'b0;
      result_p1 <= '0;
      zero_p1   <= 1'b0;
    end else if (accept) begin
      id_p1     <= grant;
      result_p1 <= alu_p0;
      zero_p1   <= (alu_p0 == '0);
    end
  end

  assign rsp_id     = id_p1;
  assign rsp_result = result_p1;
  assign rsp_zero   = zero_p1;

endmodule
